// File: rtl/fp_add_sequencer.sv
// ----------------------------------------------------------------------------
// fp_add_sequencer
//
// Multi-cycle controller and datapath for a floating-point adder. It accepts
// one operand pair per operation and keeps a single operation in flight. The
// flow is COMPARE -> ALIGN (one shift per cycle) -> ADD -> NORM (one shift per
// cycle) -> DONE. Exponents are compared by an external exponent ALU.
//
// Ports
//   Clock       rising-edge clock
//   Reset_n     asynchronous active-low reset
//   InValid     operand pair valid
//   InReady     high only while idle
//   OpA, OpB    operands {sign, exponent, mantissa}, hidden bit implied
//   AluExpA/B   captured exponents, driven to the exponent ALU
//   AluExpSet   from ALU: 1 when exponent A >= exponent B
//   AluExpDiff  from ALU: |exponent A - exponent B|
//   OutValid    result valid, held until OutReady
//   OutReady    consumer accepts the result
//   Result      packed sum
//   Overflow    result saturated to an all-ones exponent
//
// Numbers with a zero exponent are treated as zero (no denormals). There is
// no Inf/NaN handling; an all-ones exponent is an ordinary exponent.
// ----------------------------------------------------------------------------
module fp_add_sequencer #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [EXP_W+MAN_W:0]   OpA,
    input  logic [EXP_W+MAN_W:0]   OpB,
    output logic [EXP_W-1:0]       AluExpA,
    output logic [EXP_W-1:0]       AluExpB,
    input  logic                   AluExpSet,
    input  logic [EXP_W-1:0]       AluExpDiff,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [EXP_W+MAN_W:0]   Result,
    output logic                   Overflow
);

    localparam int W  = 1 + EXP_W + MAN_W;  // packed operand width
    localparam int MW = MAN_W + 1;          // mantissa with hidden bit
    localparam int SW = MAN_W + 2;          // sum width, carry bit on top
    localparam int CW = $clog2(SW + 1);     // alignment counter width

    localparam logic [CW-1:0] D_MAX = CW'(SW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Datapath registers
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [W-1:0]     res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             big_a_q, big_a_d;   // 1: A is the larger-exponent operand
    logic             sign_q, sign_d;     // sign of the pending result
    logic             first_q, first_d;   // first NORM cycle (carry handling)
    logic [MW-1:0]    sml_q, sml_d;       // smaller operand's mantissa, aligned
    logic [SW-1:0]    mant_q, mant_d;     // sum being normalised
    logic [EXP_W-1:0] exp_q, exp_d;       // result exponent
    logic [CW-1:0]    cnt_q, cnt_d;       // remaining alignment shifts

    // Operand fields
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;

    assign sign_a = opa_q[W-1];
    assign sign_b = opb_q[W-1];
    assign exp_a  = opa_q[W-2:MAN_W];
    assign exp_b  = opb_q[W-2:MAN_W];
    assign man_a  = opa_q[MAN_W-1:0];
    assign man_b  = opb_q[MAN_W-1:0];

    // COMPARE decode
    logic          zero_op;
    logic [31:0]   diff_u;
    logic [CW-1:0] d_sat;

    assign zero_op = (exp_a == '0) || (exp_b == '0);

    // Shifting further than the sum width cannot change the result, so the
    // alignment distance is capped there.
    always_comb begin
        diff_u = 32'(AluExpDiff);
        if (diff_u > 32'(SW)) begin
            d_sat = D_MAX;
        end else begin
            d_sat = CW'(AluExpDiff);
        end
    end

    // ADD: signed-magnitude add/subtract of the aligned mantissas
    logic [MW-1:0] big_man;
    logic          big_sign;
    logic          sml_sign;
    logic [SW-1:0] sum;
    logic          sum_sign;
    logic          sum_zero;

    always_comb begin
        big_man  = big_a_q ? {1'b1, man_a} : {1'b1, man_b};
        big_sign = big_a_q ? sign_a : sign_b;
        sml_sign = big_a_q ? sign_b : sign_a;
        if (sign_a == sign_b) begin
            sum      = {1'b0, big_man} + {1'b0, sml_q};
            sum_sign = big_sign;
        end else if (big_man >= sml_q) begin
            sum      = {1'b0, big_man} - {1'b0, sml_q};
            sum_sign = big_sign;
        end else begin
            // Equal exponents with the "small" operand larger in magnitude
            sum      = {1'b0, sml_q} - {1'b0, big_man};
            sum_sign = sml_sign;
        end
    end

    assign sum_zero = (sum == '0);

    // NORM decode
    logic             carry;
    logic             hidden;
    logic [EXP_W-1:0] exp_inc;
    logic             norm_done;

    assign carry     = mant_q[SW-1];
    assign hidden    = mant_q[SW-2];
    assign exp_inc   = exp_q + EXP_W'(1);
    // A carry right-shift always leaves the hidden bit set, so that cycle packs.
    assign norm_done = (first_q && carry) || hidden || (exp_q == EXP_W'(1));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (zero_op) begin
                    state_d = S_DONE;
                end else if (d_sat == '0) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                state_d = sum_zero ? S_DONE : S_NORM;
            end
            S_NORM: begin
                if (norm_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OutReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        InReady  = (state_q == S_IDLE);
        OutValid = (state_q == S_DONE);
        Result   = res_q;
        Overflow = ovf_q;
        AluExpA  = exp_a;
        AluExpB  = exp_b;
    end

    // ------------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        big_a_d = big_a_q;
        sign_d  = sign_q;
        first_d = first_q;
        sml_d   = sml_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    opa_d = OpA;
                    opb_d = OpB;
                    ovf_d = 1'b0;
                end
            end
            S_COMPARE: begin
                big_a_d = AluExpSet;
                exp_d   = AluExpSet ? exp_a : exp_b;
                sml_d   = AluExpSet ? {1'b1, man_b} : {1'b1, man_a};
                cnt_d   = d_sat;
                if (zero_op) begin
                    if (exp_a != '0) begin
                        res_d = opa_q;
                    end else if (exp_b != '0) begin
                        res_d = opb_q;
                    end else begin
                        res_d = '0;
                    end
                end
            end
            S_ALIGN: begin
                sml_d = sml_q >> 1;
                cnt_d = cnt_q - CW'(1);
            end
            S_ADD: begin
                mant_d  = sum;
                sign_d  = sum_sign;
                first_d = 1'b1;
                if (sum_zero) begin
                    res_d = '0;
                end
            end
            S_NORM: begin
                first_d = 1'b0;
                if (first_q && carry) begin
                    if (exp_inc == '1) begin
                        res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf_d = 1'b1;
                    end else begin
                        // Right shift by one folded into the pack
                        res_d = {sign_q, exp_inc, mant_q[MAN_W:1]};
                    end
                end else if (hidden) begin
                    res_d = {sign_q, exp_q, mant_q[MAN_W-1:0]};
                end else if (exp_q == EXP_W'(1)) begin
                    // Underflow: no denormals, flush to +0
                    res_d = '0;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_W'(1);
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            big_a_q <= 1'b0;
            sign_q  <= 1'b0;
            first_q <= 1'b0;
            sml_q   <= '0;
            mant_q  <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            big_a_q <= big_a_d;
            sign_q  <= sign_d;
            first_q <= first_d;
            sml_q   <= sml_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
